// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for register-array FIFOs: wrapping read/write
// pointers, one-hot write enables and read select, occupancy count and flags.
module fifo_ptr_ctrl #(
    parameter int ADDR_W = 5,
    parameter int AF_TH  = 28,
    parameter int AE_TH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [(1<<ADDR_W)-1:0]   we_onehot,
    output logic [(1<<ADDR_W)-1:0]   rd_sel_onehot,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_TH_C = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_TH_C = (ADDR_W+1)'(AE_TH);
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [ADDR_W:0] count_r;
    logic            full_r;
    logic            empty_r;
    logic            af_r;
    logic            ae_r;
    logic            overflow_r;
    logic            underflow_r;

    logic            wr_acc_s;
    logic            rd_acc_s;
    logic [ADDR_W:0] count_next_s;
    logic [ADDR_W:0] wr_ptr_next_s;
    logic [ADDR_W:0] rd_ptr_next_s;

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v    = {DEPTH{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

    function automatic logic af_of(input logic [ADDR_W:0] c);
        return (c >= AF_TH_C) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic ae_of(input logic [ADDR_W:0] c);
        return (c <= AE_TH_C) ? 1'b1 : 1'b0;
    endfunction

    // Accept logic and next-state arithmetic; clr suppresses both requests.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (clr) begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end else begin
            wr_acc_s = wr_en & (~full_r | rd_en);
            rd_acc_s = rd_en & ~empty_r;
        end
        count_next_s  = count_r + {{ADDR_W{1'b0}}, wr_acc_s} - {{ADDR_W{1'b0}}, rd_acc_s};
        wr_ptr_next_s = wr_ptr_r + {{ADDR_W{1'b0}}, wr_acc_s};
        rd_ptr_next_s = rd_ptr_r + {{ADDR_W{1'b0}}, rd_acc_s};
    end

    // Write-enable decoder: storage captures on the edge that advances wr_ptr.
    always_comb begin
        we_onehot = {DEPTH{1'b0}};
        if (wr_acc_s) begin
            we_onehot = onehot(wr_ptr_r[ADDR_W-1:0]);
        end else begin
            we_onehot = {DEPTH{1'b0}};
        end
    end

    // Pointer, count and flag registers; flags follow count_next with no lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            count_r     <= ZERO_C;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= af_of(ZERO_C);
            ae_r        <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            count_r     <= ZERO_C;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= af_of(ZERO_C);
            ae_r        <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            full_r      <= (count_next_s == DEPTH_C);
            empty_r     <= (count_next_s == ZERO_C);
            af_r        <= af_of(count_next_s);
            ae_r        <= ae_of(count_next_s);
            overflow_r  <= wr_en & full_r & ~rd_en;
            underflow_r <= rd_en & empty_r;
        end
    end

    assign rd_sel_onehot = onehot(rd_ptr_r[ADDR_W-1:0]);
    assign wr_addr       = wr_ptr_r[ADDR_W-1:0];
    assign rd_addr       = rd_ptr_r[ADDR_W-1:0];
    assign count         = count_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign almost_full   = af_r;
    assign almost_empty  = ae_r;
    assign overflow      = overflow_r;
    assign underflow     = underflow_r;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: default 32-deep instance and an 8-deep instance,
// checked every cycle against an occupancy-level model plus directed literals.
module tb_fifo_ptr_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] wr_v, rd_v, clr_v;

    logic [31:0] we0, rs0;
    logic [4:0]  wa0, ra0;
    logic [5:0]  cnt0;
    logic        full0, empty0, af0, ae0, ov0, un0;

    logic [7:0]  we1, rs1;
    logic [2:0]  wa1, ra1;
    logic [3:0]  cnt1;
    logic        full1, empty1, af1, ae1, ov1, un1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.ADDR_W(5), .AF_TH(28), .AE_TH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .wr_en(wr_v[0]), .rd_en(rd_v[0]),
        .we_onehot(we0), .rd_sel_onehot(rs0), .wr_addr(wa0), .rd_addr(ra0),
        .count(cnt0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .overflow(ov0), .underflow(un0)
    );

    fifo_ptr_ctrl #(.ADDR_W(3), .AF_TH(6), .AE_TH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .wr_en(wr_v[1]), .rd_en(rd_v[1]),
        .we_onehot(we1), .rd_sel_onehot(rs1), .wr_addr(wa1), .rd_addr(ra1),
        .count(cnt1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .overflow(ov1), .underflow(un1)
    );

    logic [31:0] act_we [2];
    logic [31:0] act_rs [2];
    logic [31:0] act_wa [2];
    logic [31:0] act_ra [2];
    logic [31:0] act_cnt [2];
    logic [5:0]  act_fl [2];
    assign act_we[0]  = we0;
    assign act_we[1]  = {24'd0, we1};
    assign act_rs[0]  = rs0;
    assign act_rs[1]  = {24'd0, rs1};
    assign act_wa[0]  = {27'd0, wa0};
    assign act_wa[1]  = {29'd0, wa1};
    assign act_ra[0]  = {27'd0, ra0};
    assign act_ra[1]  = {29'd0, ra1};
    assign act_cnt[0] = {26'd0, cnt0};
    assign act_cnt[1] = {28'd0, cnt1};
    assign act_fl[0]  = {full0, empty0, af0, ae0, ov0, un0};
    assign act_fl[1]  = {full1, empty1, af1, ae1, ov1, un1};

    // Model: FIFO as an occupancy level plus head/tail slot numbers.
    int m_depth [2] = '{32, 8};
    int m_af    [2] = '{28, 6};
    int m_ae    [2] = '{4, 1};
    int m_cnt [2];
    int m_wp  [2];
    int m_rp  [2];
    bit m_ov  [2];
    bit m_un  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr_v[k]) begin
                m_cnt[k] <= 0; m_wp[k] <= 0; m_rp[k] <= 0;
                m_ov[k] <= 1'b0; m_un[k] <= 1'b0;
            end else begin
                automatic bit wa = wr_v[k] && (m_cnt[k] < m_depth[k] || rd_v[k]);
                automatic bit ra = rd_v[k] && (m_cnt[k] > 0);
                m_cnt[k] <= m_cnt[k] + int'(wa) - int'(ra);
                m_wp[k]  <= (m_wp[k] + int'(wa)) % m_depth[k];
                m_rp[k]  <= (m_rp[k] + int'(ra)) % m_depth[k];
                m_ov[k]  <= wr_v[k] && (m_cnt[k] == m_depth[k]) && !rd_v[k];
                m_un[k]  <= rd_v[k] && (m_cnt[k] == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output of both instances against the model.
    initial begin
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            #3;
            for (int k = 0; k < 2; k++) begin
                automatic logic [31:0] one = 32'd1;
                automatic bit wa_now = rst_n && wr_v[k] && !clr_v[k] &&
                                       (m_cnt[k] < m_depth[k] || rd_v[k]);
                automatic logic [31:0] e_we = wa_now ? (one << m_wp[k]) : 32'd0;
                automatic logic [5:0] e_fl = {m_cnt[k] == m_depth[k], m_cnt[k] == 0,
                                              m_cnt[k] >= m_af[k], m_cnt[k] <= m_ae[k],
                                              m_ov[k], m_un[k]};
                chk($sformatf("m%0d_we", k), act_we[k], e_we);
                chk($sformatf("m%0d_rsel", k), act_rs[k], one << m_rp[k]);
                chk($sformatf("m%0d_waddr", k), act_wa[k], 32'(m_wp[k]));
                chk($sformatf("m%0d_raddr", k), act_ra[k], 32'(m_rp[k]));
                chk($sformatf("m%0d_count", k), act_cnt[k], 32'(m_cnt[k]));
                chk($sformatf("m%0d_flags", k), {26'd0, act_fl[k]}, {26'd0, e_fl});
            end
        end
    end

    task automatic drive(input int k, input bit w, input bit r, input bit c);
        @(negedge clk);
        #1;
        wr_v = 2'b00; rd_v = 2'b00; clr_v = 2'b00;
        wr_v[k] = w; rd_v[k] = r; clr_v[k] = c;
        #1;
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        logic [31:0] one;
        one = 32'd1;
        rst_n = 1'b0;
        wr_v = 2'b00; rd_v = 2'b00; clr_v = 2'b00;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        drive(0, 0, 0, 0);
        chk("rst_count", {26'd0, cnt0}, 32'd0);
        chk("rst_empty", {31'd0, empty0}, 32'd1);
        chk("rst_ae", {31'd0, ae0}, 32'd1);
        chk("rst_af", {31'd0, af0}, 32'd0);
        chk("rst_rsel", rs0, 32'h1);
        chk("rst_we", we0, 32'h0);

        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 0, 0);
            chk("fill_we", we0, one << i);
            chk("fill_count", {26'd0, cnt0}, 32'(i));
            if (i == 27) chk("af_below", {31'd0, af0}, 32'd0);
            if (i == 28) chk("af_at28", {31'd0, af0}, 32'd1);
        end
        drive(0, 0, 0, 0);
        chk("full_set", {31'd0, full0}, 32'd1);
        chk("full_count", {26'd0, cnt0}, 32'd32);

        drive(0, 1, 0, 0);
        chk("ovf_we", we0, 32'h0);
        drive(0, 0, 0, 0);
        chk("ovf_pulse", {31'd0, ov0}, 32'd1);
        chk("ovf_count", {26'd0, cnt0}, 32'd32);
        chk("ovf_waddr", {27'd0, wa0}, 32'd0);
        drive(0, 0, 0, 0);
        chk("ovf_clear", {31'd0, ov0}, 32'd0);

        drive(0, 1, 1, 0);
        chk("fullrw_we", we0, 32'h1);
        drive(0, 0, 0, 0);
        chk("fullrw_count", {26'd0, cnt0}, 32'd32);
        chk("fullrw_raddr", {27'd0, ra0}, 32'd1);

        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 1, 0);
            chk("drain_rsel", rs0, one << ((i + 1) % 32));
        end
        drive(0, 1, 1, 0);
        chk("empty_rw_we", we0, 32'h2);
        drive(0, 0, 0, 0);
        chk("udf_pulse", {31'd0, un0}, 32'd1);
        chk("udf_count", {26'd0, cnt0}, 32'd1);
        chk("udf_empty", {31'd0, empty0}, 32'd0);
        drive(0, 0, 0, 0);
        chk("udf_clear", {31'd0, un0}, 32'd0);

        drive(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        chk("clr_we", we0, 32'h0);
        drive(0, 0, 0, 0);
        chk("clr_count", {26'd0, cnt0}, 32'd0);
        chk("clr_empty", {31'd0, empty0}, 32'd1);
        chk("clr_waddr", {27'd0, wa0}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0);
            chk("s_we", {24'd0, we1}, one << i);
            if (i == 5) chk("s_af_below", {31'd0, af1}, 32'd0);
            if (i == 6) chk("s_af_at6", {31'd0, af1}, 32'd1);
        end
        drive(1, 0, 0, 0);
        chk("s_full", {31'd0, full1}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 0);
            chk("s_rsel", {24'd0, rs1}, one << i);
            if (i == 6) chk("s_ae_above", {31'd0, ae1}, 32'd0);
            if (i == 7) chk("s_ae_at1", {31'd0, ae1}, 32'd1);
        end
        drive(1, 0, 0, 0);
        chk("s_empty", {31'd0, empty1}, 32'd1);
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        chk("s_wrap_we", {24'd0, we1}, 32'h1);
        drive(1, 0, 0, 0);
        chk("s_wrap_count", {28'd0, cnt1}, 32'd8);
        chk("s_wrap_raddr", {29'd0, ra1}, 32'd1);
        chk("s_wrap_waddr", {29'd0, wa1}, 32'd1);

        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        @(negedge clk);
        #1;
        wr_v = 2'b00; rd_v = 2'b00; clr_v = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {26'd0, cnt0}, 32'd0);
        chk("arst_empty", {31'd0, empty0}, 32'd1);
        chk("arst_waddr", {27'd0, wa0}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) drive(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Parametrised pointer and flag controller for register-array FIFOs.
- Replaces the fixed 5-to-32 write-select decoder with a generic one-hot decoder of width 2^ADDR_W, driven from internal wrapping read/write pointers.
- Adds full, empty, almost-full, almost-empty, occupancy count and error pulses.
- Sits between producer/consumer handshakes and the FIFO storage array. The storage uses we_onehot as per-word write enables and rd_sel_onehot as the read mux select.

Parameters:
ADDR_W, 5, pointer address width; DEPTH = 2^ADDR_W words (default 32).
AF_TH, 28, almost_full asserts when count >= AF_TH (1..DEPTH).
AE_TH, 4, almost_empty asserts when count <= AE_TH (0..DEPTH-1).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear; pointers and count return to reset state; has priority over wr_en/rd_en.
wr_en  in  1  producer write request.
rd_en  in  1  consumer read request.
we_onehot  out  DEPTH  one-hot word write enable for the current write slot; all zero when the write is not accepted.
rd_sel_onehot  out  DEPTH  one-hot select of the word at the read pointer; valid whenever empty=0.
wr_addr  out  ADDR_W  binary write address (wr_ptr low bits).
rd_addr  out  ADDR_W  binary read address (rd_ptr low bits).
count  out  ADDR_W+1  occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_TH.
almost_empty  out  1  count <= AE_TH.
overflow  out  1  one-cycle pulse on a rejected write.
underflow  out  1  one-cycle pulse on a rejected read.

Behaviour:
Clock and reset:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (assuming AF_TH>0), overflow=0, underflow=0.
- At reset, we_onehot=0 and rd_sel_onehot = bit0 set.

Pointers and count:
- Internal wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit. Each increments by 1 modulo 2^(ADDR_W+1) on an accepted operation.
- wr_acc = wr_en & (~full | rd_en). A write into a full FIFO is accepted only when paired with a read, which is always accepted when full.
- rd_acc = rd_en & ~empty. A read on an empty FIFO is rejected even if wr_en=1; that write is accepted.
- count_next = count + wr_acc - rd_acc. Simultaneous accepted read and write leave count unchanged and advance both pointers.

Outputs and flags:
- full, empty, almost_full, almost_empty and count are registered. They are computed from count_next and update on the same edge as the pointers, with zero-cycle flag lag.
- we_onehot = wr_acc ? (1 << wr_ptr[ADDR_W-1:0]) : 0. It is combinational and valid within the request cycle. The storage captures data on the same edge that advances wr_ptr.
- rd_sel_onehot = 1 << rd_ptr[ADDR_W-1:0]. It is combinational from the register, giving zero-latency read data (first-word-fall-through).
- overflow is registered: set for exactly one cycle when wr_en & full & ~rd_en.
- underflow is registered: set for exactly one cycle when rd_en & empty.

Boundary conditions:
- Wrap-around: at address DEPTH-1 the pointer's low bits roll to 0 and the wrap bit toggles. Full and empty are tracked by count, never inferred from pointer equality alone.
- clr: next edge forces reset values (including overflow=0, underflow=0). Any wr_en/rd_en in the same cycle is ignored and we_onehot is forced to 0 during the clr cycle.
- rst_n asserted mid-operation: all state clears immediately, without waiting for clk. Stored words are not touched, but are logically discarded.
- Exactly one bit of we_onehot is high per accepted write, never more.

Test Plan:
1. Reset, then 32 consecutive writes (wr_en=1) -> we_onehot walks 0x00000001..0x80000000; count 1..32; almost_full rises when count reaches 28; full=1 after the 32nd write.
2. From full, wr_en=1, rd_en=0 -> we_onehot=0, overflow pulses for 1 cycle, count stays 32, wr_addr unchanged.
3. From full, wr_en=1 and rd_en=1 for 1 cycle -> both accepted; we_onehot=0x00000001 (wrapped); count stays 32; rd_addr 0->1.
4. Drain all words, then rd_en=1 on empty with wr_en=1 -> read rejected, underflow pulses, write accepted, count=1, empty deasserts next edge.
5. Write 10 words, assert clr together with wr_en -> next cycle count=0, empty=1, wr_addr=0, we_onehot=0 during the clr cycle.
6. ADDR_W=3, AF_TH=6, AE_TH=1: 8 writes then 8 reads -> we_onehot 8 bits wide, almost_full at count=6, almost_empty at count<=1, rd_sel_onehot walks 0x01..0x80, and a final full write/read cycle wraps both pointers.
